dl_write_buffer: RTL and testbench
==================================

# dl_write_buffer

Buffers the byte stream of the SPI download path (ROM/CAS/cartridge images) and turns it into word-addressed SDRAM write requests for the memory controller inside the core. It sits directly downstream of the `data_io` ioctl outputs and upstream of the SDRAM port. It paces the producer through `clkref`, drains outstanding writes when the download ends, and reports completion with a single-cycle pulse.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries; power of two, minimum 2.
- `AW`, 25: width of the ioctl byte address.

Ports:
- `clk_sys` in 1: system clock, 50 MHz domain.
- `reset_n` in 1: asynchronous active-low reset.
- `dn_go` in 1: download active, level signal from `data_io`.
- `dn_wr` in 1: byte strobe, one cycle wide.
- `dn_addr` in AW: byte address.
- `dn_data` in 8: byte data.
- `dn_idx` in 6: image index.
- `clkref` out 1: producer enable; `data_io` issues `dn_wr` only while this is high.
- `mem_req` out 1: write request.
- `mem_ack` in 1: single-cycle completion pulse from the controller.
- `mem_addr` out AW-1: word address.
- `mem_din` out 16: write data.
- `mem_be` out 2: byte enables; `[0]` is the low byte (DQML), `[1]` is the high byte (DQMH).
- `mem_idx` out 6: `dn_idx` latched on the rising edge of `dn_go`.
- `busy` out 1: high in LOAD and DRAIN.
- `done` out 1: one-cycle pulse after the last write is acknowledged.
- `overflow` out 1: sticky flag; cleared on the next `dn_go` rise.

## Operation
- Reset value of every output is 0, except `clkref`, which resets to 1.
- Each FIFO entry holds `{word_addr, data16, be}`.
- Byte-to-lane mapping:
  - `dn_addr[0]=0` gives `be=01` with the data in `[7:0]`.
  - `dn_addr[0]=1` gives `be=10` with the data in `[15:8]`.
  - In both cases `word_addr = dn_addr[AW-1:1]`.
- States:
  - **IDLE → LOAD** on the `dn_go` rise. This transition latches `mem_idx` and clears `overflow`.
  - **LOAD → DRAIN** on the `dn_go` fall.
  - **DRAIN → DONE** when the FIFO is empty, the pack register is empty (see Configuration), and no request is outstanding.
  - **DONE → IDLE** after one cycle, with `done=1` during that cycle.
  - A `dn_go` rise while in DRAIN or DONE is registered and causes entry to LOAD immediately after DONE; it is never lost.
- `dn_wr` is honoured in LOAD only; a strobe in any other state is ignored.
- `clkref` = (FIFO count < DEPTH-1). This leaves one slot of slack for a strobe already in flight.
- `dn_wr` with the FIFO full: the byte is dropped, `overflow` is set, and the FIFO is unchanged.
- Memory handshake:
  - `mem_req`, `mem_addr`, `mem_din` and `mem_be` are registered and stay stable while `mem_req=1`.
  - On the `mem_ack` cycle, `mem_req` falls at the next edge.
  - The next head entry is loaded at that same edge, so `mem_req` is low for exactly one cycle between transfers.
  - `mem_ack` while `mem_req=0` is ignored.
- Push and pop in the same cycle leave the count unchanged. The read and write pointers wrap modulo DEPTH.
- Reset asserted mid-operation: the FIFO, pack register and outstanding request are discarded, and no `done` is produced.

## Timing
- `dn_wr` is sampled at edge 0 into an empty FIFO with no outstanding request: `mem_req=1` after edge 1, so latency is 1 cycle.
- Sustained throughput is one write per 2 cycles plus the controller's ack latency.
- `done` rises 1 cycle after the final `mem_ack`, provided `dn_go` is already low.
- `clkref` updates 1 cycle after the count change.

## Configuration
- `DL_WORD_PACK_EN` defined:
  - An even-address byte is held in a pack register and not pushed.
  - If the next accepted byte has `dn_addr` equal to held+1, a single entry with `be=11` is pushed.
  - Any other next byte pushes the held byte alone (`be=01`), and the new byte is then handled normally.
  - A `dn_go` fall flushes the held byte before DRAIN can complete.
  - A flush that finds the FIFO full waits and asserts nothing extra.
- `DL_WORD_PACK_EN` undefined: no pack register; every byte produces one write with a single-lane `be`.

## Test plan
- **Single byte:** `dn_go` rise, `dn_wr` with addr 0x000003 / data 0xA5, `dn_go` fall, ack after 3 cycles → one request with `mem_addr=0x1`, `mem_din[15:8]=0xA5`, `be=10`; `done` one cycle after the ack.
- **Back-pressure:** controller never acks, 5 strobes with DEPTH=4 → `clkref` low at count 3, `overflow` set by the 5th strobe, FIFO still holding 4 entries.
- **Pack** (macro on): bytes at 0x10=0x11 and 0x11=0x22 → one write with `mem_addr=0x8`, `mem_din=0x2211`, `be=11`. Pack off: the same input gives two writes with `be=01` then `be=10`.
- **Non-consecutive pack** (macro on): bytes at 0x10 then 0x14 → writes at word 0x8 (`be=01`) and word 0xA (`be=01`). An odd final byte is flushed at the `dn_go` fall.
- **Reset mid-drain:** `reset_n` low while 3 entries are queued → all outputs at reset values immediately, `clkref=1`, no `done` afterwards.
- **Re-trigger:** `dn_go` re-rises during DRAIN with idx 2 → `done` pulses, then LOAD is entered with `mem_idx=2` and `overflow` cleared.

Source files
------------

// File: rtl/dl_write_buffer.sv
// dl_write_buffer: collects the ioctl byte stream of the SPI download path in a
// small FIFO and issues one registered SDRAM word write per entry.
// Optional feature: define DL_WORD_PACK_EN to merge an even byte with the
// following odd byte of the same word into a single two-lane write.
module dl_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 25
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dn_go,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [7:0]    dn_data,
    input  logic [5:0]    dn_idx,
    output logic          clkref,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-2:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_be,
    output logic [5:0]    mem_idx,
    output logic          busy,
    output logic          done,
    output logic          overflow
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL  = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_SLACK = (PW+1)'(DEPTH-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic          go_d;
    logic          go_pend;
    logic [5:0]    idx_pend;
    logic          go_rise;
    logic          enter_load;

    logic [AW-2:0] fifo_addr [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [1:0]    fifo_be   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_nxt;
    logic [PW:0]   count;
    logic          fifo_full;

    logic          accept;
    logic          push;
    logic          pop;
    logic          drop;
    logic          pack_empty;
    logic [AW-2:0] push_addr;
    logic [15:0]   push_data;
    logic [1:0]    push_be;
    logic [AW-2:0] byte_addr;
    logic [15:0]   byte_data;
    logic [1:0]    byte_be;

    assign go_rise    = dn_go && !go_d;
    assign enter_load = (go_rise && (state == S_IDLE)) ||
                        ((state == S_DONE) && (go_pend || go_rise));
    assign fifo_full  = (count == CNT_FULL);
    assign accept     = (state == S_LOAD) && dn_wr;
    assign pop        = mem_req && mem_ack;
    assign rd_nxt     = rd_ptr + 1'b1;

    assign byte_addr  = dn_addr[AW-1:1];
    assign byte_data  = dn_addr[0] ? {dn_data, 8'h00} : {8'h00, dn_data};
    assign byte_be    = dn_addr[0] ? 2'b10 : 2'b01;

`ifdef DL_WORD_PACK_EN
    logic          pack_vld;
    logic [AW-1:0] pack_addr;
    logic [7:0]    pack_data;
    logic [AW-1:0] pack_next;
    logic          pair;
    logic          flush;
    logic          hold_new;

    assign pack_next  = pack_addr + 1'b1;
    assign pair       = accept && pack_vld && !pack_addr[0] && (dn_addr == pack_next);
    assign flush      = (state == S_DRAIN) && pack_vld && !fifo_full;
    assign pack_empty = !pack_vld;

    // Decide what enters the FIFO; a non-matching byte evicts the held one and
    // takes its place, so at most one entry is pushed per cycle.
    always_comb begin
        push      = 1'b0;
        drop      = 1'b0;
        hold_new  = 1'b0;
        push_addr = byte_addr;
        push_data = byte_data;
        push_be   = byte_be;
        if (accept) begin
            if (pair) begin
                push_addr = pack_addr[AW-1:1];
                push_data = {dn_data, pack_data};
                push_be   = 2'b11;
                drop      = fifo_full;
                push      = !fifo_full;
            end else if (pack_vld) begin
                push_addr = pack_addr[AW-1:1];
                push_data = pack_addr[0] ? {pack_data, 8'h00} : {8'h00, pack_data};
                push_be   = pack_addr[0] ? 2'b10 : 2'b01;
                drop      = fifo_full;
                push      = !fifo_full;
                hold_new  = !fifo_full;
            end else if (!dn_addr[0]) begin
                hold_new  = 1'b1;
            end else begin
                drop      = fifo_full;
                push      = !fifo_full;
            end
        end else if (flush) begin
            push_addr = pack_addr[AW-1:1];
            push_data = pack_addr[0] ? {pack_data, 8'h00} : {8'h00, pack_data};
            push_be   = pack_addr[0] ? 2'b10 : 2'b01;
            push      = 1'b1;
        end
    end

    // Pack register: holds one byte waiting for its partner lane.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pack_vld  <= 1'b0;
            pack_addr <= '0;
            pack_data <= '0;
        end else if (hold_new) begin
            pack_vld  <= 1'b1;
            pack_addr <= dn_addr;
            pack_data <= dn_data;
        end else if ((pair && !fifo_full) || flush) begin
            pack_vld  <= 1'b0;
        end
    end
`else
    assign push       = accept && !fifo_full;
    assign drop       = accept && fifo_full;
    assign push_addr  = byte_addr;
    assign push_data  = byte_data;
    assign push_be    = byte_be;
    assign pack_empty = 1'b1;
`endif

    // FIFO storage, written at the tail.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= push_data;
            fifo_be[wr_ptr]   <= push_be;
        end
    end

    // Pointers, occupancy, pacing, overflow flag and the memory request registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            clkref   <= 1'b1;
            overflow <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_be   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            clkref <= (count < CNT_SLACK);
            if (enter_load)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            // The entry stays in the FIFO until acked; on the ack the following
            // entry is presented at once and mem_req re-rises one cycle later.
            if (pop) begin
                mem_req <= 1'b0;
                rd_ptr  <= rd_nxt;
                if (count[PW:1] != '0) begin
                    mem_addr <= fifo_addr[rd_nxt];
                    mem_din  <= fifo_data[rd_nxt];
                    mem_be   <= fifo_be[rd_nxt];
                end
            end else if (!mem_req && (count != '0)) begin
                mem_req  <= 1'b1;
                mem_addr <= fifo_addr[rd_ptr];
                mem_din  <= fifo_data[rd_ptr];
                mem_be   <= fifo_be[rd_ptr];
            end
        end
    end

    // Download state machine with registered busy/done/mem_idx.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            go_d     <= 1'b0;
            go_pend  <= 1'b0;
            idx_pend <= '0;
            mem_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            go_d <= dn_go;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enter_load) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        mem_idx <= dn_idx;
                    end
                end
                S_LOAD: begin
                    if (!dn_go)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (go_rise) begin
                        go_pend  <= 1'b1;
                        idx_pend <= dn_idx;
                    end
                    if ((count == '0) && pack_empty && !mem_req) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (enter_load) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        mem_idx <= go_pend ? idx_pend : dn_idx;
                        go_pend <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dl_write_buffer.sv
// Directed bench for dl_write_buffer (DEPTH=4, AW=25).
module tb_dl_write_buffer;
    logic        clk_sys;
    logic        reset_n;
    logic        dn_go;
    logic        dn_wr;
    logic [24:0] dn_addr;
    logic [7:0]  dn_data;
    logic [5:0]  dn_idx;
    logic        clkref;
    logic        mem_req;
    logic        mem_ack;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic [5:0]  mem_idx;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_checks = 0;
    int n_fails  = 0;

    dl_write_buffer #(.DEPTH(4), .AW(25)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .dn_go   (dn_go),
        .dn_wr   (dn_wr),
        .dn_addr (dn_addr),
        .dn_data (dn_data),
        .dn_idx  (dn_idx),
        .clkref  (clkref),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_be  (mem_be),
        .mem_idx (mem_idx),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    initial clk_sys = 1'b0;
    always #10 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        tick();
        dn_wr   = 1'b0;
    endtask

    // Wait for a request, check it against the expected word, then ack it.
    task automatic drain_one(input string tag, input logic [23:0] ea,
                             input logic [1:0] ebe, input logic [15:0] edin);
        int n;
        logic [15:0] mask;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        mask = {{8{ebe[1]}}, {8{ebe[0]}}};
        chk({tag, "_req"},  32'(mem_req), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, "_be"},   32'(mem_be), 32'(ebe));
        chk({tag, "_din"},  32'(mem_din & mask), 32'(edin & mask));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_rel"},  32'(mem_req), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic seen_done;
        logic seen_req;

        reset_n = 1'b0;
        dn_go   = 1'b0;
        dn_wr   = 1'b0;
        dn_addr = '0;
        dn_data = '0;
        dn_idx  = '0;
        mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_clkref",   32'(clkref), 32'd1);
        chk("rst_req",      32'(mem_req), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_idx",      32'(mem_idx), 32'd0);
        chk("rst_be",       32'(mem_be), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single odd byte: latency, stability while unacked, done after ack.
        dn_idx = 6'd5;
        dn_go  = 1'b1;
        tick();
        chk("sb_busy", 32'(busy), 32'd1);
        chk("sb_idx",  32'(mem_idx), 32'd5);
        strobe(25'h000003, 8'hA5);
        chk("sb_lat0", 32'(mem_req), 32'd0);
        dn_go = 1'b0;
        tick();
        chk("sb_lat1", 32'(mem_req), 32'd1);
        tick();
        tick();
        drain_one("sb", 24'h000001, 2'b10, 16'hA500);
        chk("sb_nodone", 32'(done), 32'd0);
        tick();
        chk("sb_done",  32'(done), 32'd1);
        chk("sb_idle",  32'(busy), 32'd0);
        tick();
        chk("sb_pulse", 32'(done), 32'd0);

        // Consecutive even/odd bytes of one word.
        dn_go = 1'b1;
        tick();
        strobe(25'h000010, 8'h11);
        strobe(25'h000011, 8'h22);
        dn_go = 1'b0;
`ifdef DL_WORD_PACK_EN
        drain_one("pk", 24'h000008, 2'b11, 16'h2211);
`else
        drain_one("pk_lo", 24'h000008, 2'b01, 16'h0011);
        drain_one("pk_hi", 24'h000008, 2'b10, 16'h2200);
`endif
        wait_done("pk");
        tick();

        // Non-consecutive bytes plus an odd final byte.
        dn_go = 1'b1;
        tick();
        strobe(25'h000010, 8'h5A);
        strobe(25'h000014, 8'h6B);
        strobe(25'h000017, 8'h7C);
        dn_go = 1'b0;
        drain_one("nc0", 24'h000008, 2'b01, 16'h005A);
        drain_one("nc1", 24'h00000A, 2'b01, 16'h006B);
        drain_one("nc2", 24'h00000B, 2'b10, 16'h7C00);
        wait_done("nc");
        tick();

        // Back-pressure with no acks, then a re-trigger during DRAIN.
        dn_idx = 6'd9;
        dn_go  = 1'b1;
        tick();
        strobe(25'h000021, 8'h31);
        strobe(25'h000023, 8'h32);
        strobe(25'h000025, 8'h33);
        chk("bp_clkref_c3pre", 32'(clkref), 32'd1);
        strobe(25'h000027, 8'h34);
        chk("bp_clkref_low", 32'(clkref), 32'd0);
        chk("bp_ovf_clear",  32'(overflow), 32'd0);
        strobe(25'h000029, 8'h35);
        chk("bp_ovf_set",    32'(overflow), 32'd1);
        chk("bp_head_addr",  32'(mem_addr), 32'h10);
        dn_go = 1'b0;
        tick();
        dn_idx = 6'd2;
        dn_go  = 1'b1;
        drain_one("bp0", 24'h000010, 2'b10, 16'h3100);
        drain_one("bp1", 24'h000011, 2'b10, 16'h3200);
        drain_one("bp2", 24'h000012, 2'b10, 16'h3300);
        drain_one("bp3", 24'h000013, 2'b10, 16'h3400);
        wait_done("rt");
        chk("rt_ovf_sticky", 32'(overflow), 32'd1);
        chk("rt_busy_done",  32'(busy), 32'd0);
        tick();
        chk("rt_busy", 32'(busy), 32'd1);
        chk("rt_idx",  32'(mem_idx), 32'd2);
        chk("rt_ovf",  32'(overflow), 32'd0);
        chk("rt_done_low", 32'(done), 32'd0);
        chk("rt_clkref", 32'(clkref), 32'd1);
        dn_go = 1'b0;
        wait_done("rt_end");
        tick();

        // Reset while three entries are queued in DRAIN.
        dn_idx = 6'd7;
        dn_go  = 1'b1;
        tick();
        strobe(25'h000041, 8'h41);
        strobe(25'h000043, 8'h42);
        strobe(25'h000045, 8'h43);
        dn_go = 1'b0;
        tick();
        chk("rd_pre_req", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rd_req",    32'(mem_req), 32'd0);
        chk("rd_clkref", 32'(clkref), 32'd1);
        chk("rd_busy",   32'(busy), 32'd0);
        chk("rd_idx",    32'(mem_idx), 32'd0);
        chk("rd_addr",   32'(mem_addr), 32'd0);
        tick();
        reset_n   = 1'b1;
        seen_done = 1'b0;
        seen_req  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1)
                seen_done = 1'b1;
            if (mem_req === 1'b1)
                seen_req = 1'b1;
        end
        chk("rd_no_done", 32'(seen_done), 32'd0);
        chk("rd_no_req",  32'(seen_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
